// File: rtl/bin2bcd_if.sv
// Handshake and result bundle between a binary source and the bin2bcd_seq converter.
// The master requests conversions; the slave (converter) reports busy/done and the result.
interface bin2bcd_if #(
   parameter int W      = 16,
   parameter int DIGITS = 5
);
   logic                  start;
   logic [W-1:0]          bin;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd;
   logic [DIGITS-1:0]     lz;

   modport master (
      output start,
      output bin,
      input  busy,
      input  done,
      input  bcd,
      input  lz
   );

   modport slave (
      input  start,
      input  bin,
      output busy,
      output done,
      output bcd,
      output lz
   );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Produces packed BCD digits plus a leading-zero blanking mask for the LCD formatter.
module bin2bcd_seq #(
   parameter int W      = 16,
   parameter int DIGITS = 5
) (
   input  logic      clk,
   input  logic      rst,
   bin2bcd_if.slave  bus
);
   localparam int CNT_W = $clog2(W + 1);
   localparam int BCD_W = 4 * DIGITS;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;

   logic [W-1:0]        bin_sr;
   logic [BCD_W-1:0]    work;
   logic [BCD_W-1:0]    work_adj;
   logic [BCD_W-1:0]    work_nxt;
   logic [W-1:0]        bin_sr_nxt;
   logic [CNT_W-1:0]    cnt;
   logic [BCD_W-1:0]    bcd_q;
   logic [DIGITS-1:0]   lz_q;
   logic                accept;
   logic                last;

   // Per-digit correction: 0-4 unchanged, 5-9 become 8-12 so the next shift carries.
   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? (d + 4'd3) : d;
   endfunction

   // Bit i set when digit i and every higher digit are zero; the units digit is never blanked.
   function automatic logic [DIGITS-1:0] lead_zero(input logic [BCD_W-1:0] v);
      logic [DIGITS-1:0] m;
      logic              all_zero;
      m        = '0;
      all_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         all_zero = all_zero && (v[4*i +: 4] == 4'd0);
         m[i]     = all_zero;
      end
      return m;
   endfunction

   always_comb begin
      work_adj = '0;
      for (int i = 0; i < DIGITS; i++) begin
         work_adj[4*i +: 4] = add3(work[4*i +: 4]);
      end
      // The digit MSB shifted out is always zero when DIGITS is sized for 2^W-1.
      work_nxt   = (work_adj << 1) | {{(BCD_W-1){1'b0}}, bin_sr[W-1]};
      bin_sr_nxt = bin_sr << 1;
   end

   assign last = (state == SHIFT) && (cnt == CNT_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept    = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (bus.start) begin
               accept    = 1'b1;
               state_nxt = SHIFT;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bin_sr <= '0;
         work   <= '0;
         cnt    <= '0;
         bcd_q  <= '0;
         lz_q   <= {{(DIGITS-1){1'b1}}, 1'b0};
      end else if (accept) begin
         bin_sr <= bus.bin;
         work   <= '0;
         cnt    <= CNT_W'(W);
      end else if (state == SHIFT) begin
         bin_sr <= bin_sr_nxt;
         work   <= work_nxt;
         cnt    <= cnt - CNT_W'(1);
         // Outputs only change on the final shift, so they never show partial results.
         if (last) begin
            bcd_q <= work_nxt;
            lz_q  <= lead_zero(work_nxt);
         end
      end
   end

   assign bus.busy = (state == SHIFT);
   assign bus.done = (state == DONE);
   assign bus.bcd  = bcd_q;
   assign bus.lz   = lz_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and randomized bench for bin2bcd_seq: latency, handshake, abort and digit correctness.
module tb_bin2bcd_seq;
   localparam int W      = 16;
   localparam int DIGITS = 5;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;
   int   bad_digit;

   bin2bcd_if #(.W(W), .DIGITS(DIGITS)) bus ();

   bin2bcd_seq #(.W(W), .DIGITS(DIGITS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Working digits must stay below 10 at every point of every conversion.
   always @(negedge clk) begin
      for (int i = 0; i < DIGITS; i++) begin
         if (dut.work[4*i +: 4] > 4'd9) bad_digit++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(output int cycles, output int busy_cyc);
      cycles   = 0;
      busy_cyc = 0;
      while (!bus.done && cycles < 100) begin
         if (bus.busy) busy_cyc++;
         step();
         cycles++;
      end
   endtask

   function automatic logic [19:0] ref_bcd(input int unsigned v);
      logic [19:0] r;
      int unsigned x;
      r = '0;
      x = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [4:0] ref_lz(input int unsigned v);
      int unsigned p;
      logic [4:0]  m;
      m = '0;
      p = 1;
      for (int i = 1; i < DIGITS; i++) begin
         p = p * 10;
         m[i] = (v < p);
      end
      return m;
   endfunction

   task automatic start_conv(input logic [15:0] v);
      bus.bin   = v;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   int cyc, bcyc, ndone;

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      bad_digit = 0;
      bus.start = 1'b0;
      bus.bin   = '0;
      rst       = 1'b1;
      step();
      step();
      rst = 1'b0;

      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_bcd",  32'(bus.bcd),  32'h0);
      check("rst_lz",   32'(bus.lz),   32'b11110);

      // Zero input: latency, busy length and result.
      start_conv(16'd0);
      check("zero_busy_on_accept", 32'(bus.busy), 32'd1);
      wait_done(cyc, bcyc);
      check("zero_done", 32'(bus.done), 32'd1);
      check("zero_latency", 32'(cyc), 32'd16);
      check("zero_busy_cycles", 32'(bcyc), 32'd16);
      check("zero_bcd", 32'(bus.bcd), 32'h00000);
      check("zero_lz", 32'(bus.lz), 32'b11110);
      step();
      check("zero_done_pulse", 32'(bus.done), 32'd0);
      check("zero_idle_busy", 32'(bus.busy), 32'd0);

      // Full-scale input.
      start_conv(16'hFFFF);
      wait_done(cyc, bcyc);
      check("max_done", 32'(bus.done), 32'd1);
      check("max_bcd", 32'(bus.bcd), 32'h65535);
      check("max_lz", 32'(bus.lz), 32'b00000);
      step();
      check("max_done_pulse", 32'(bus.done), 32'd0);

      // Back-to-back: second start presented during the DONE cycle.
      start_conv(16'd9);
      wait_done(cyc, bcyc);
      check("b2b_first_done", 32'(bus.done), 32'd1);
      check("b2b_first_bcd", 32'(bus.bcd), 32'h00009);
      check("b2b_first_lz", 32'(bus.lz), 32'b11110);
      start_conv(16'd10);
      wait_done(cyc, bcyc);
      check("b2b_second_done", 32'(bus.done), 32'd1);
      check("b2b_spacing", 32'(cyc + 1), 32'd17);
      check("b2b_second_bcd", 32'(bus.bcd), 32'h00010);
      check("b2b_second_lz", 32'(bus.lz), 32'b11100);
      step();

      // Start pulse while busy is ignored.
      start_conv(16'd1234);
      repeat (4) step();
      bus.bin   = 16'd999;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check("ign_bcd_held", 32'(bus.bcd), 32'h00010);
      wait_done(cyc, bcyc);
      check("ign_done", 32'(bus.done), 32'd1);
      check("ign_bcd", 32'(bus.bcd), 32'h01234);
      check("ign_lz", 32'(bus.lz), 32'b10000);
      ndone = 0;
      repeat (25) begin
         step();
         if (bus.done) ndone++;
      end
      check("ign_no_second_done", 32'(ndone), 32'd0);

      // Reset aborts an in-flight conversion.
      start_conv(16'd4321);
      repeat (7) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_bcd", 32'(bus.bcd), 32'h0);
      check("abort_lz", 32'(bus.lz), 32'b11110);
      ndone = 0;
      repeat (25) begin
         step();
         if (bus.done) ndone++;
      end
      check("abort_no_done", 32'(ndone), 32'd0);
      start_conv(16'd50);
      wait_done(cyc, bcyc);
      check("after_abort_done", 32'(bus.done), 32'd1);
      check("after_abort_bcd", 32'(bus.bcd), 32'h00050);
      check("after_abort_lz", 32'(bus.lz), 32'b11100);
      step();

      // Random sweep against the decimal reference.
      for (int n = 0; n < 1000; n++) begin
         int unsigned v;
         v = $urandom_range(0, 65535);
         start_conv(16'(v));
         wait_done(cyc, bcyc);
         check("rand_bcd", 32'(bus.bcd), 32'(ref_bcd(v)));
         check("rand_lz", 32'(bus.lz), 32'(ref_lz(v)));
         step();
      end

      check("digit_lt10", 32'(bad_digit), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
